dmem_access_ctrl: RTL and testbench

//  MEM-stage front end between the pipeline and the data cache/BRAM port.
//  - Latches one load/store request.
//  - Drives the memory handshake and stalls the pipeline until the memory completes.
//  - Builds big-endian byte enables and lane-replicated store data.
//  - Hands the word-aligned read word, byte offset and funct3 to the downstream load formatter.

---
 rtl/dmem_access_ctrl_pkg.sv | 41 ++++
 rtl/dmem_access_ctrl_if.sv | 24 ++
 rtl/dmem_access_ctrl_store_align.sv | 35 +++
 rtl/dmem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// funct3 encodings, FSM state encoding, byte-enable constants and the
// alignment helper used by the optional misaligned-access trap.
package dmem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Halfwords need an even address, words (and the 11 size that is
    // treated as a word) need a word-aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data memory port bundle between the access controller (master) and the
// data cache / BRAM port (slave).
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_byte_en;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_store_align.sv
// Combinational store lane steering: turns access size, byte offset and
// the rs2 datum into big-endian byte enables ([3] = offset 0) and
// lane-replicated write data. Misaligned halfword/word offsets are simply
// truncated to their natural lane group.
module dmem_store_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata
);

    // Select lane group and replicate the datum across the word
    always_comb begin
        byte_en = BE_WORD;
        wdata   = rs2;
        case (size)
            SZ_BYTE: begin
                byte_en = BE_B0 >> offset;
                wdata   = {4{rs2[7:0]}};
            end
            SZ_HALF: begin
                byte_en = offset[1] ? BE_H_LO : BE_H_HI;
                wdata   = {2{rs2[15:0]}};
            end
            default: begin
                byte_en = BE_WORD;
                wdata   = rs2;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage front end between the pipeline and the data memory port.
// Latches one load/store, runs the request/grant/rvalid handshake while
// stalling the pipeline, and hands the captured read word plus offset and
// funct3 to the downstream load formatter.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W accesses skip
// the memory and raise a one-cycle misalign pulse instead).
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                stall,
    dmem_access_ctrl_if.master  mem,
    output logic                ld_valid,
    output logic [31:0]         ld_data,
    output logic [1:0]          ld_byte_offset,
    output logic [2:0]          ld_dm_select,
    output logic                misalign
);

    state_t            state;
    state_t            state_next;
    logic              capture;
    logic              req_mis;
    logic              mis_q;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    assign req_mis = is_misaligned(req_funct3[1:0], req_addr[1:0]);

    // Remember whether the latched access is trapping as misaligned
    always_ff @(posedge clk) begin
        if (!nrst) begin
            mis_q <= 1'b0;
        end else if (state == ST_IDLE && req_valid) begin
            mis_q <= req_mis;
        end
    end
`else
    assign req_mis = 1'b0;
    assign mis_q   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and read-data capture strobe
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = req_mis ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_gnt) begin
                    if (r_we) begin
                        state_next = ST_DONE;
                    end else if (mem.mem_rvalid) begin
                        state_next = ST_DONE;
                        capture    = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_next = ST_DONE;
                    capture    = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the request fields on the IDLE entry cycle
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
        end else if (state == ST_IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W+1:0];
            r_wdata  <= req_wdata;
        end
    end

    // Capture the read word and load descriptors as the load completes
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ld_data        <= 32'h0;
            ld_byte_offset <= 2'b00;
            ld_dm_select   <= 3'b000;
        end else if (capture) begin
            ld_data        <= mem.mem_rdata;
            ld_byte_offset <= r_addr[1:0];
            ld_dm_select   <= r_funct3;
        end
    end

    dmem_store_align u_store_align (
        .size    (r_funct3[1:0]),
        .offset  (r_addr[1:0]),
        .rs2     (r_wdata),
        .byte_en (al_be),
        .wdata   (al_wdata)
    );

    assign stall           = (state == ST_IDLE && req_valid) || (state == ST_REQ) || (state == ST_WAIT);
    assign mem.mem_req     = (state == ST_REQ);
    assign mem.mem_we      = (state == ST_REQ) && r_we;
    assign mem.mem_addr    = r_addr[ADDR_W+1:2];
    assign mem.mem_byte_en = ((state == ST_REQ) && r_we) ? al_be : BE_NONE;
    assign mem.mem_wdata   = al_wdata;
    assign ld_valid        = (state == ST_DONE) && !r_we && !mis_q;
    assign misalign        = (state == ST_DONE) && mis_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by
// randomized loads/stores with random grant and read latencies, compared
// against a transaction-level reference model.
// Honours MISALIGN_TRAP_EN when the build defines it.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 12;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [1:0]  ld_byte_offset;
    logic [2:0]  ld_dm_select;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    // Reference state: what the load formatter should currently see
    logic [31:0] m_ld_data;
    logic [1:0]  m_off;
    logic [2:0]  m_sel;

    dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .mem            (mem_bus),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_byte_offset (ld_byte_offset),
        .ld_dm_select   (ld_dm_select),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    // Access size in bytes from funct3 (11 behaves as a word)
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Big-endian lanes: byte at offset k is enable bit 3-k
    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
        int n;
        int first;
        logic [3:0] be;
        n     = size_bytes(f3);
        first = (int'(off) / n) * n;
        be    = 4'b0000;
        for (int k = 0; k < n; k++) be[3 - (first + k)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = size_bytes(f3);
        if (n == 1) return {24'h0, d[7:0]} * 32'h01010101;
        if (n == 2) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic bit exp_trap(input logic [2:0] f3, input logic [31:0] addr);
        return TRAP_EN && ((int'(addr[1:0]) % size_bytes(f3)) != 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete access; called at a negedge with the DUT in IDLE
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                                 input logic [31:0] rdata);
        bit trap;
        trap       = exp_trap(f3, addr);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        #1;
        checkOutput("idle_stall", stall, 1);
        checkOutput("idle_mem_req", mem_bus.mem_req, 0);
        @(negedge clk);
        if (trap) begin
            #1;
            checkOutput("trap_mem_req", mem_bus.mem_req, 0);
            checkOutput("trap_misalign", misalign, 1);
            checkOutput("trap_ld_valid", ld_valid, 0);
            checkOutput("trap_stall", stall, 0);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                mem_bus.mem_gnt    = (i == gnt_dly);
                mem_bus.mem_rvalid = !we && (i == gnt_dly) && (rv_dly == 0);
                mem_bus.mem_rdata  = mem_bus.mem_rvalid ? rdata : $urandom;
                #1;
                checkOutput("req_mem_req", mem_bus.mem_req, 1);
                checkOutput("req_stall", stall, 1);
                checkOutput("req_mem_addr", mem_bus.mem_addr, addr[ADDR_W+1:2]);
                checkOutput("req_mem_we", mem_bus.mem_we, we);
                checkOutput("req_byte_en", mem_bus.mem_byte_en, we ? exp_be(f3, addr[1:0]) : 4'b0000);
                if (we) checkOutput("req_wdata", mem_bus.mem_wdata, exp_wdata(f3, wdata));
                @(negedge clk);
            end
            mem_bus.mem_gnt    = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            if (!we && rv_dly > 0) begin
                for (int i = 1; i <= rv_dly; i++) begin
                    mem_bus.mem_rvalid = (i == rv_dly);
                    mem_bus.mem_rdata  = mem_bus.mem_rvalid ? rdata : $urandom;
                    #1;
                    checkOutput("wait_mem_req", mem_bus.mem_req, 0);
                    checkOutput("wait_stall", stall, 1);
                    @(negedge clk);
                end
                mem_bus.mem_rvalid = 1'b0;
            end
            if (!we) begin
                m_ld_data = rdata;
                m_off     = addr[1:0];
                m_sel     = f3;
            end
            #1;
            checkOutput("done_stall", stall, 0);
            checkOutput("done_mem_req", mem_bus.mem_req, 0);
            checkOutput("done_ld_valid", ld_valid, !we);
            checkOutput("done_misalign", misalign, 0);
            if (!we) begin
                checkOutput("done_ld_data", ld_data, m_ld_data);
                checkOutput("done_ld_off", ld_byte_offset, m_off);
                checkOutput("done_ld_sel", ld_dm_select, m_sel);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_ld_valid", ld_valid, 0);
        checkOutput("post_stall", stall, 0);
        checkOutput("post_misalign", misalign, 0);
        checkOutput("hold_ld_data", ld_data, m_ld_data);
        checkOutput("hold_ld_off", ld_byte_offset, m_off);
        checkOutput("hold_ld_sel", ld_dm_select, m_sel);
    endtask

    initial begin
        logic [2:0] ld_f3_tab [5];
        logic [2:0] f3;
        logic       we;
        ld_f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        nrst               = 1'b0;
        req_valid          = 1'b0;
        req_we             = 1'b0;
        req_funct3         = 3'b000;
        req_addr           = 32'h0;
        req_wdata          = 32'h0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;
        m_ld_data          = 32'h0;
        m_off              = 2'b00;
        m_sel              = 3'b000;

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_mem_req", mem_bus.mem_req, 0);
        checkOutput("rst_ld_valid", ld_valid, 0);
        checkOutput("rst_ld_data", ld_data, 0);
        checkOutput("rst_misalign", misalign, 0);
        @(negedge clk);
        nrst = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b1, 3'b010, 32'h0000_0010, 32'hAABBCCDD, 0, 0, 32'h0);
        applyStimulus(1'b1, 3'b000, 32'h0000_0013, 32'h000000EE, 0, 0, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0106, 32'h1234BEEF, 2, 0, 32'h0);
        applyStimulus(1'b1, 3'b011, 32'h0000_0FFC, 32'h87654321, 1, 0, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h0000_0021, 32'h0, 0, 3, 32'h11223344);
        applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 0, 32'h55667788);
        applyStimulus(1'b0, 3'b010, 32'h0000_0022, 32'h0, 1, 1, 32'h99AABBCC);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            we = $urandom_range(0, 1);
            f3 = we ? 3'($urandom_range(0, 3)) : ld_f3_tab[$urandom_range(0, 4)];
            applyStimulus(we, f3, $urandom, $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom);
        end

        $display("[TB] reset during WAIT");
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0020;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
        #1;
        checkOutput("rstwait_stall", stall, 1);
        checkOutput("rstwait_mem_req", mem_bus.mem_req, 0);
        nrst      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        nrst               = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hDEADBEEF;
        #1;
        checkOutput("rstwait_idle_stall", stall, 0);
        checkOutput("rstwait_idle_req", mem_bus.mem_req, 0);
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        m_ld_data = 32'h0;
        m_off     = 2'b00;
        m_sel     = 3'b000;
        #1;
        checkOutput("rstwait_ld_valid", ld_valid, 0);
        checkOutput("rstwait_ld_data", ld_data, m_ld_data);
        @(negedge clk);
        #1;
        checkOutput("rstwait_ld_valid2", ld_valid, 0);
        checkOutput("rstwait_stall2", stall, 0);

        applyStimulus(1'b0, 3'b101, 32'h0000_0032, 32'h0, 0, 2, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
